adc_burst_packer: RTL and testbench

//   Packs the continuous ADC sample stream into fixed-length bursts and writes them to the fill FIFO.

---
 rtl/adc_pkg.sv | 14 +
 rtl/adc_burst_packer_if.sv | 25 ++
 rtl/adc_sample_shreg.sv | 39 +++
 rtl/adc_burst_packer.sv | 90 +++++++++
 tb/tb_adc_burst_packer.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/adc_pkg.sv
// adc_pkg: shared state type and default geometry for the ADC burst packer
package adc_pkg;

    localparam int SAMPLE_W_DEF  = 12;
    localparam int BURST_LEN_DEF = 8;
    localparam int IDX_W         = $clog2(BURST_LEN_DEF);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DONE
    } state_t;

endpackage

// File: rtl/adc_burst_packer_if.sv
// adc_burst_packer_if: ADC sample stream in, packed-burst FIFO write port out
interface adc_burst_packer_if
    import adc_pkg::*;
#(
    parameter int SAMPLE_W  = SAMPLE_W_DEF,
    parameter int BURST_LEN = BURST_LEN_DEF
) ();

    logic                          adc_valid;
    logic [SAMPLE_W-1:0]           adc_data;
    logic                          fifo_full;
    logic                          fifo_wr_en;
    logic [SAMPLE_W*BURST_LEN-1:0] fifo_din;

    modport master (
        input  adc_valid, adc_data, fifo_full,
        output fifo_wr_en, fifo_din
    );

    modport slave (
        output adc_valid, adc_data, fifo_full,
        input  fifo_wr_en, fifo_din
    );

endinterface

// File: rtl/adc_sample_shreg.sv
// adc_sample_shreg: collects BURST_LEN samples into a packed burst and flags the completing sample
module adc_sample_shreg
    import adc_pkg::*;
#(
    parameter int SAMPLE_W  = SAMPLE_W_DEF,
    parameter int BURST_LEN = BURST_LEN_DEF
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          en,
    input  logic                          din_valid,
    input  logic [SAMPLE_W-1:0]           din,
    output logic                          complete,
    output logic [SAMPLE_W*BURST_LEN-1:0] burst
);

    localparam int IW = $clog2(BURST_LEN);
    localparam int SW = SAMPLE_W * (BURST_LEN - 1);

    logic [IW-1:0] idx;
    logic [SW-1:0] slots;
    logic          store;

    assign store    = en && din_valid;
    assign complete = store && idx == IW'(BURST_LEN - 1);
    // The last sample is never stored: it joins the burst straight from the input.
    assign burst    = {din, slots};

    // Shift samples toward the LSBs so the oldest ends up in slot 0
    always_ff @(posedge clk)
        if (reset) slots <= '0;
        else if (store) slots <= {din, slots[SW-1:SAMPLE_W]};

    // Sample index, held at 0 while capture is off so every fill starts at slot 0
    always_ff @(posedge clk)
        if (reset || !en) idx <= '0;
        else if (store) idx <= complete ? '0 : idx + 1'b1;

endmodule

// File: rtl/adc_burst_packer.sv
// adc_burst_packer: packs ADC samples into bursts, writes them to the fill FIFO, ends on counter zero
module adc_burst_packer
    import adc_pkg::*;
#(
    parameter int SAMPLE_W  = SAMPLE_W_DEF,
    parameter int BURST_LEN = BURST_LEN_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               trigger,
    input  logic               burst_at_zero,
    output logic               burst_init,
    output logic               burst_enable,
    output logic               busy,
    output logic               fill_done,
    output logic               overflow_err,
    adc_burst_packer_if.master bus
);

    state_t                        state, state_n;
    logic                          init_n, en_n, wr_n, ovf_n, wr_q, complete;
    logic [SAMPLE_W*BURST_LEN-1:0] din_n, din_q, burst;

    adc_sample_shreg #(
        .SAMPLE_W (SAMPLE_W),
        .BURST_LEN(BURST_LEN)
    ) u_shreg (
        .clk      (clk),
        .reset    (reset),
        .en       (state == FILL),
        .din_valid(bus.adc_valid),
        .din      (bus.adc_data),
        .complete (complete),
        .burst    (burst)
    );

    assign bus.fifo_wr_en = wr_q;
    assign bus.fifo_din   = din_q;

    // Next state and next values of every registered output
    always_comb begin
        state_n = state;
        init_n  = 1'b0;
        en_n    = 1'b0;
        wr_n    = 1'b0;
        ovf_n   = overflow_err;
        din_n   = din_q;
        case (state)
            IDLE: if (trigger) begin
                state_n = FILL;
                init_n  = 1'b1;
                ovf_n   = 1'b0;
            end
            FILL: if (complete) begin
                if (burst_at_zero) state_n = DONE;
                else begin
                    // A burst lost to a full FIFO still counts, so fill length stays fixed in time.
                    en_n  = 1'b1;
                    wr_n  = !bus.fifo_full;
                    ovf_n = overflow_err || bus.fifo_full;
                    din_n = bus.fifo_full ? din_q : burst;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk)
        if (reset) begin
            state        <= IDLE;
            burst_init   <= 1'b0;
            burst_enable <= 1'b0;
            wr_q         <= 1'b0;
            din_q        <= '0;
            overflow_err <= 1'b0;
            busy         <= 1'b0;
            fill_done    <= 1'b0;
        end else begin
            state        <= state_n;
            burst_init   <= init_n;
            burst_enable <= en_n;
            wr_q         <= wr_n;
            din_q        <= din_n;
            overflow_err <= ovf_n;
            busy         <= state_n == FILL;
            fill_done    <= state_n == DONE;
        end

endmodule

// File: tb/tb_adc_burst_packer.sv
// tb_adc_burst_packer: randomized fills checked against a sample-list model of the burst packer
module tb_adc_burst_packer;

    localparam int W = 12;
    localparam int L = 8;
    localparam int D = W * L;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic trigger = 1'b0;
    logic burst_at_zero;
    logic burst_init, burst_enable, busy, fill_done, overflow_err;

    adc_burst_packer_if #(.SAMPLE_W(W), .BURST_LEN(L)) bus ();

    adc_burst_packer #(.SAMPLE_W(W), .BURST_LEN(L)) dut (
        .clk          (clk),
        .reset        (reset),
        .trigger      (trigger),
        .burst_at_zero(burst_at_zero),
        .burst_init   (burst_init),
        .burst_enable (burst_enable),
        .busy         (busy),
        .fill_done    (fill_done),
        .overflow_err (overflow_err),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int n_cfg = 0;
    int cnt;

    logic         v_a [0:8191];
    logic         f_a [0:8191];
    logic [W-1:0] d_a [0:8191];

    int           q_init[$], q_en[$], q_wr[$], q_done[$];
    logic         q_ovi[$], q_ovd[$];
    logic [D-1:0] q_wd[$];
    int           n_busy = 0;

    // Burst down-counter of the parent: at_zero is registered after the count, two cycles behind a pulse
    always @(posedge clk)
        if (reset) begin
            cnt           <= 0;
            burst_at_zero <= 1'b1;
        end else begin
            if (burst_init) cnt <= n_cfg;
            else if (burst_enable && cnt != 0) cnt <= cnt - 1;
            burst_at_zero <= (cnt == 0);
        end

    // Output event log, sampled mid-cycle
    always @(negedge clk) begin
        if (burst_init) begin q_init.push_back(cyc); q_ovi.push_back(overflow_err); end
        if (burst_enable) q_en.push_back(cyc);
        if (bus.fifo_wr_en) begin q_wr.push_back(cyc); q_wd.push_back(bus.fifo_din); end
        if (fill_done) begin q_done.push_back(cyc); q_ovd.push_back(overflow_err); end
        if (busy) n_busy++;
    end

    task automatic check(input string tag, input logic [D-1:0] got, input logic [D-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic trg, input logic vld, input logic full);
        @(posedge clk);
        #1;
        cyc++;
        trigger       = trg;
        bus.adc_valid = vld;
        bus.adc_data  = W'($urandom);
        bus.fifo_full = full;
        v_a[cyc & 8191] = vld;
        d_a[cyc & 8191] = bus.adc_data;
        f_a[cyc & 8191] = full;
        @(negedge clk);
        #1;
    endtask

    function automatic logic vld_of(input int mode, input int i);
        return mode == 0 ? 1'b1 : mode == 1 ? (i % 2 == 1) : ($urandom % 4 != 0);
    endfunction

    // One fill: trigger while idle, run until fill_done, then compare against the model
    task automatic run_fill(input int n, input int vmode, input int flo, input int fhi,
                            input bit rfull, input int tmode);
        int t, lim, got_n, s_i, s_e, s_w, s_d, s_b, ns, b, e_done;
        bit e_ovf;
        int e_en[$], e_wr[$];
        logic [D-1:0] e_wd[$];
        logic [D-1:0] pk;
        n_cfg = n;
        step(0, 0, 0);
        step(0, 0, 0);
        s_i = q_init.size(); s_e = q_en.size(); s_w = q_wr.size(); s_d = q_done.size(); s_b = n_busy;
        step(1, 0, 0);
        t = cyc;
        lim = 0;
        while (q_done.size() == s_d && lim < 400) begin
            lim++;
            step(tmode == 2 ? 1'b1 : tmode == 1 ? logic'($urandom % 2) : 1'b0, vld_of(vmode, lim),
                 (lim >= flo && lim <= fhi) || (rfull && $urandom % 8 == 0));
        end
        check("fill_timeout", lim < 400, 1);
        for (int i = 0; i < 4; i++) step(0, 0, 0);
        // Model: captured samples are the valid ones from the init cycle on, grouped L at a time
        ns = 0; b = 0; e_done = -1; e_ovf = 0; pk = '0;
        for (int c = t + 1; c <= cyc && e_done < 0; c++)
            if (v_a[c & 8191]) begin
                pk[ns*W +: W] = d_a[c & 8191];
                ns++;
                if (ns == L) begin
                    ns = 0;
                    if (b == n) e_done = c + 1;
                    else begin
                        e_en.push_back(c + 1);
                        if (f_a[c & 8191]) e_ovf = 1;
                        else begin e_wr.push_back(c + 1); e_wd.push_back(pk); end
                    end
                    b++;
                end
            end
        check("init_cnt", q_init.size() - s_i, 1);
        check("init_cyc", q_init.size() > s_i ? q_init[s_i] : -1, t + 1);
        check("ovf_clr", q_ovi.size() > s_i ? q_ovi[s_i] : 1'b1, 0);
        check("en_cnt", q_en.size() - s_e, e_en.size());
        for (int i = 0; i < e_en.size(); i++)
            check("en_cyc", q_en.size() > s_e + i ? q_en[s_e+i] : -1, e_en[i]);
        got_n = q_wr.size() - s_w;
        check("wr_cnt", got_n, e_wr.size());
        for (int i = 0; i < e_wr.size(); i++) begin
            check("wr_cyc", got_n > i ? q_wr[s_w+i] : -1, e_wr[i]);
            check("wr_data", got_n > i ? q_wd[s_w+i] : '1, e_wd[i]);
        end
        check("done_cnt", q_done.size() - s_d, 1);
        check("done_cyc", q_done.size() > s_d ? q_done[s_d] : -1, e_done);
        check("ovf_done", q_ovd.size() > s_d ? q_ovd[s_d] : 1'bx, e_ovf);
        check("busy_cycles", n_busy - s_b, e_done - (t + 1));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int t, s_w, s_d;
        bus.adc_valid = 1'b0;
        bus.adc_data  = '0;
        bus.fifo_full = 1'b0;
        for (int i = 0; i < 3; i++) step(0, 0, 0);
        reset = 1'b0;
        check("rst_init", burst_init, 0);
        check("rst_en", burst_enable, 0);
        check("rst_wr", bus.fifo_wr_en, 0);
        check("rst_din", bus.fifo_din, 0);
        check("rst_busy", busy, 0);
        check("rst_done", fill_done, 0);
        check("rst_ovf", overflow_err, 0);

        run_fill(3, 0, -1, -1, 0, 0);
        run_fill(0, 0, -1, -1, 0, 0);
        run_fill(2, 1, -1, -1, 0, 0);
        run_fill(4, 0, 10, 17, 0, 0);
        check("ovf_sticky", overflow_err, 1);
        run_fill(3, 0, -1, -1, 0, 2);
        run_fill(3, 2, -1, -1, 0, 1);

        // Reset in the middle of burst 2 of a 5-burst fill, after burst 1 overflowed
        n_cfg = 5;
        step(0, 0, 0);
        s_w = q_wr.size(); s_d = q_done.size();
        step(1, 0, 0);
        t = cyc;
        for (int i = 0; i < 13; i++) step(0, 1, i == 7);
        check("mid_ovf", overflow_err, 1);
        check("mid_busy", busy, 1);
        reset = 1'b1;
        step(0, 1, 0);
        check("mr_init", burst_init, 0);
        check("mr_en", burst_enable, 0);
        check("mr_wr", bus.fifo_wr_en, 0);
        check("mr_din", bus.fifo_din, 0);
        check("mr_busy", busy, 0);
        check("mr_done", fill_done, 0);
        check("mr_ovf", overflow_err, 0);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) step(0, 1, 0);
        check("mr_no_wr", q_wr.size() - s_w, 0);
        check("mr_no_done", q_done.size() - s_d, 0);
        check("mr_idle", busy, 0);
        run_fill(2, 0, -1, -1, 0, 0);

        for (int r = 0; r < 6; r++) run_fill(int'($urandom % 5), 2, -1, -1, 1, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
